// File: rtl/fft_out_reorder.sv
// Double-buffered reorder stage: stores 8-point FFT frames in bit-reversed order
// and streams them out in natural frequency order with valid/ready on both sides.
module fft_out_reorder #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned N_PTS  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic [2:0]        out_idx,
  output logic              out_last
);

  localparam int unsigned IDX_W = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PTS - 1);

  typedef enum logic {W_FILL, W_WAIT}  wstate_t;
  typedef enum logic {R_IDLE, R_DRAIN} rstate_t;

  wstate_t wstate, wstate_nxt;
  rstate_t rstate, rstate_nxt;

  logic [DATA_W-1:0] mem_re [2][N_PTS];
  logic [DATA_W-1:0] mem_im [2][N_PTS];

  logic [1:0]       full, full_nxt;
  logic             wbank, wbank_nxt, rbank, rbank_nxt;
  logic [IDX_W-1:0] wcnt, wcnt_nxt, rcnt, rcnt_nxt;
  logic             wr_fire, wr_last, rd_fire, rd_last;

  function automatic logic [IDX_W-1:0] bitrev3(input logic [IDX_W-1:0] a);
    return {a[0], a[1], a[2]};
  endfunction

  assign in_ready = !reset && (wstate == W_FILL) && !full[wbank];
  assign wr_fire  = in_valid && in_ready;
  assign wr_last  = wr_fire && (wcnt == LAST_IDX);
  assign rd_fire  = (rstate == R_DRAIN) && out_ready;
  assign rd_last  = rd_fire && (rcnt == LAST_IDX);

  // Outputs are forced to zero when idle so unreset bank contents never leak out.
  always_comb begin
    out_valid = (rstate == R_DRAIN);
    out_re    = '0;
    out_im    = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    if (out_valid) begin
      out_re   = mem_re[rbank][rcnt];
      out_im   = mem_im[rbank][rcnt];
      out_idx  = rcnt;
      out_last = (rcnt == LAST_IDX);
    end
  end

  // Next-state: the read side looks at next-cycle full flags so a frame completing
  // on this edge is presented on the very next cycle, and drains chain without gaps.
  always_comb begin
    full_nxt   = full;
    wbank_nxt  = wbank ^ wr_last;
    rbank_nxt  = rbank ^ rd_last;
    wcnt_nxt   = wcnt + IDX_W'(wr_fire);
    rcnt_nxt   = rcnt + IDX_W'(rd_fire);
    wstate_nxt = wstate;
    rstate_nxt = rstate;
    if (wr_last) full_nxt[wbank] = 1'b1;
    if (rd_last) full_nxt[rbank] = 1'b0;

    case (wstate)
      W_FILL:  if (wr_last && full_nxt[wbank_nxt]) wstate_nxt = W_WAIT;
      W_WAIT:  if (!full[wbank]) wstate_nxt = W_FILL;
      default: wstate_nxt = W_FILL;
    endcase

    case (rstate)
      R_IDLE:  if (full_nxt[rbank]) rstate_nxt = R_DRAIN;
      R_DRAIN: if (rd_last && !full_nxt[rbank_nxt]) rstate_nxt = R_IDLE;
      default: rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wstate <= W_FILL;
      rstate <= R_IDLE;
      full   <= '0;
      wbank  <= 1'b0;
      rbank  <= 1'b0;
      wcnt   <= '0;
      rcnt   <= '0;
    end else begin
      wstate <= wstate_nxt;
      rstate <= rstate_nxt;
      full   <= full_nxt;
      wbank  <= wbank_nxt;
      rbank  <= rbank_nxt;
      wcnt   <= wcnt_nxt;
      rcnt   <= rcnt_nxt;
    end
  end

  // Sample k of a frame lands at its bit-reversed address, i.e. its natural index.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_re[wbank][bitrev3(wcnt)] <= in_re;
      mem_im[wbank][bitrev3(wcnt)] <= in_im;
    end
  end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed bench for fft_out_reorder: reorder values, latency, throughput,
// backpressure, stall stability, mid-frame reset and input gaps.
module tb_fft_out_reorder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_re;
  logic [15:0] in_im;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_re;
  logic [15:0] out_im;
  logic [2:0]  out_idx;
  logic        out_last;

  int tests_run    = 0;
  int tests_failed = 0;

  fft_out_reorder #(.DATA_W(16), .N_PTS(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_idx(out_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Natural-order expectations for the in_re = 0x0100*k, in_im = -in_re frame.
  logic [15:0] exp_a_re [8] = '{16'h0000, 16'h0400, 16'h0200, 16'h0600,
                                16'h0100, 16'h0500, 16'h0300, 16'h0700};
  logic [15:0] exp_a_im [8] = '{16'h0000, 16'hFC00, 16'hFE00, 16'hFA00,
                                16'hFF00, 16'hFB00, 16'hFD00, 16'hF900};
  // Expectations for in_re = 0x1000 + k, in_im = 0x2000 + k.
  logic [15:0] exp_b_re [8] = '{16'h1000, 16'h1004, 16'h1002, 16'h1006,
                                16'h1001, 16'h1005, 16'h1003, 16'h1007};
  logic [15:0] exp_b_im [8] = '{16'h2000, 16'h2004, 16'h2002, 16'h2006,
                                16'h2001, 16'h2005, 16'h2003, 16'h2007};

  int          cyc = 0;
  int          acc_cnt = 0;
  int          last_acc_cyc = 0;
  logic [35:0] out_q [$];
  int          out_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes are observed mid-cycle; the transfer happens on the following edge.
  always @(negedge clk) begin
    if (in_valid && in_ready) begin
      acc_cnt      = acc_cnt + 1;
      last_acc_cyc = cyc;
    end
    if (out_valid && out_ready) begin
      out_q.push_back({out_re, out_im, out_idx, out_last});
      out_cyc.push_back(cyc);
    end
  end

  task automatic clear_mon();
    out_q.delete();
    out_cyc.delete();
    acc_cnt = 0;
  endtask

  task automatic send(input logic [15:0] re, input logic [15:0] im, input bit gap);
    int n;
    bit acc;
    n = 0;
    if (gap) begin
      while ($urandom_range(1, 0) == 1 && n < 4) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
        n++;
      end
    end
    in_valid = 1'b1; in_re = re; in_im = im;
    n = 0; acc = 1'b0;
    do begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 200);
    in_valid = 1'b0;
    if (!acc) begin
      tests_run++; tests_failed++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end
  endtask

  task automatic wait_out(input int n);
    for (int t = 0; t < 400 && out_q.size() < n; t++) begin
      @(posedge clk); #1;
    end
    tests_run++;
    if (out_q.size() != n) begin
      tests_failed++;
      $display("FAIL out_count: got %0d outputs, required %0d", out_q.size(), n);
    end
  endtask

  task automatic test_reset();
    logic [35:0] got;
    reset = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL reset_in_ready_low: got %b, required 0", in_ready);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_in_ready_high: got %b, required 1", in_ready);
    end
    got = {out_re, out_im, out_idx, out_last};
    tests_run++;
    if ({out_valid, got} !== 37'h0) begin
      tests_failed++; $display("FAIL reset_outputs: got %h, required 0", {out_valid, got});
    end
  endtask

  task automatic test_single_frame();
    logic [35:0] exp;
    clear_mon();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) send(16'(16'h0100 * k), 16'(-(16'h0100 * k)), 1'b0);
    wait_out(8);
    tests_run++;
    if (out_cyc.size() > 0 && out_cyc[0] !== last_acc_cyc + 1) begin
      tests_failed++;
      $display("FAIL single_latency: first out cycle %0d, required %0d", out_cyc[0], last_acc_cyc + 1);
    end
    for (int i = 0; i < 8 && i < out_q.size(); i++) begin
      exp = {exp_a_re[i], exp_a_im[i], 3'(i), i == 7};
      tests_run++;
      if (out_q[i] !== exp) begin
        tests_failed++; $display("FAIL single_out%0d: got %h, required %h", i, out_q[i], exp);
      end
    end
    tests_run++;
    if ({out_valid, out_re, out_im, out_idx, out_last} !== 37'h0) begin
      tests_failed++;
      $display("FAIL idle_outputs_zero: got %h, required 0", {out_valid, out_re, out_im, out_idx, out_last});
    end
  endtask

  task automatic test_back_to_back();
    logic [35:0] exp;
    int c0, nerr;
    clear_mon();
    out_ready = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 24; i++) send(16'(16'h0100 * (i % 8)), 16'(-(16'h0100 * (i % 8))), 1'b0);
    tests_run++;
    if (cyc - c0 != 24) begin
      tests_failed++; $display("FAIL b2b_in_cycles: took %0d cycles, required 24", cyc - c0);
    end
    wait_out(24);
    nerr = 0;
    for (int i = 1; i < out_cyc.size(); i++) if (out_cyc[i] != out_cyc[i-1] + 1) nerr++;
    tests_run++;
    if (nerr != 0) begin
      tests_failed++; $display("FAIL b2b_out_gaps: got %0d gaps, required 0", nerr);
    end
    for (int i = 0; i < out_q.size(); i++) begin
      exp = {exp_a_re[i%8], exp_a_im[i%8], 3'(i % 8), (i % 8) == 7};
      tests_run++;
      if (out_q[i] !== exp) begin
        tests_failed++; $display("FAIL b2b_out%0d: got %h, required %h", i, out_q[i], exp);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [35:0] exp;
    clear_mon();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(16'(16'h0100 * (i % 8)), 16'(-(16'h0100 * (i % 8))), 1'b0);
    in_valid = 1'b1; in_re = 16'h0AAA; in_im = 16'h0555;
    repeat (3) begin @(posedge clk); #1; end
    tests_run++;
    if (acc_cnt != 16 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_full: accepted %0d in_ready %b, required 16 and 0", acc_cnt, in_ready);
    end
    tests_run++;
    if ({out_valid, out_idx, out_re} !== {1'b1, 3'd0, 16'h0000}) begin
      tests_failed++;
      $display("FAIL bp_hold: got %h, required %h", {out_valid, out_idx, out_re}, {1'b1, 3'd0, 16'h0000});
    end
    out_ready = 1'b1;
    for (int t = 0; t < 100 && out_q.size() < 8; t++) begin @(posedge clk); #1; end
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL bp_no_bypass: in_ready %b after 8th output edge, required 0", in_ready);
    end
    @(posedge clk); #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL bp_ready_rise: in_ready %b one cycle later, required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests_run++;
    if (acc_cnt != 17) begin
      tests_failed++; $display("FAIL bp_17th_accept: accepted %0d, required 17", acc_cnt);
    end
    for (int k = 1; k < 8; k++) send(16'(16'h0100 * k), 16'(-(16'h0100 * k)), 1'b0);
    wait_out(24);
    for (int i = 0; i < out_q.size(); i++) begin
      exp = {exp_a_re[i%8], exp_a_im[i%8], 3'(i % 8), (i % 8) == 7};
      if (i == 16) exp = {16'h0AAA, 16'h0555, 3'd0, 1'b0};
      tests_run++;
      if (out_q[i] !== exp) begin
        tests_failed++; $display("FAIL bp_out%0d: got %h, required %h", i, out_q[i], exp);
      end
    end
  endtask

  task automatic test_stall_toggle();
    logic [36:0] snap, prev;
    logic [35:0] exp;
    bit prev_stall;
    clear_mon();
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) send(16'(16'h0100 * k), 16'(-(16'h0100 * k)), 1'b0);
    prev_stall = 1'b0; prev = '0;
    for (int t = 0; t < 100 && out_q.size() < 8; t++) begin
      snap = {out_valid, out_re, out_im, out_idx, out_last};
      if (prev_stall) begin
        tests_run++;
        if (snap !== prev) begin
          tests_failed++; $display("FAIL stall_hold_t%0d: got %h, required %h", t, snap, prev);
        end
      end
      out_ready  = ~out_ready;
      prev_stall = out_valid && !out_ready;
      prev       = snap;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_out(8);
    for (int i = 0; i < out_q.size(); i++) begin
      exp = {exp_a_re[i], exp_a_im[i], 3'(i), i == 7};
      tests_run++;
      if (out_q[i] !== exp) begin
        tests_failed++; $display("FAIL stall_out%0d: got %h, required %h", i, out_q[i], exp);
      end
    end
  endtask

  task automatic test_gaps();
    logic [35:0] exp;
    clear_mon();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) send(16'(16'h0100 * k), 16'(-(16'h0100 * k)), 1'b1);
    wait_out(8);
    for (int i = 0; i < out_q.size(); i++) begin
      exp = {exp_a_re[i], exp_a_im[i], 3'(i), i == 7};
      tests_run++;
      if (out_q[i] !== exp) begin
        tests_failed++; $display("FAIL gaps_out%0d: got %h, required %h", i, out_q[i], exp);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [35:0] exp;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) send(16'h7777, 16'h7777, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL midreset_in_ready: got %b, required 0", in_ready);
    end
    reset = 1'b0;
    clear_mon();
    for (int k = 0; k < 8; k++) send(16'(16'h1000 + k), 16'(16'h2000 + k), 1'b0);
    wait_out(8);
    tests_run++;
    if (out_cyc.size() > 0 && out_cyc[0] !== last_acc_cyc + 1) begin
      tests_failed++;
      $display("FAIL midreset_latency: first out cycle %0d, required %0d", out_cyc[0], last_acc_cyc + 1);
    end
    for (int i = 0; i < out_q.size(); i++) begin
      exp = {exp_b_re[i], exp_b_im[i], 3'(i), i == 7};
      tests_run++;
      if (out_q[i] !== exp) begin
        tests_failed++; $display("FAIL midreset_out%0d: got %h, required %h", i, out_q[i], exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_stall_toggle();
    test_gaps();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
